// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core
// Ports: clk/reset (sync, active-high); Opcode/Funct from the IR; Zero from the ALU;
// datapath enables PCWrite/IorD/MemRead/MemWrite/IRWrite/RegWrite/RegDst/MemtoReg;
// mux selects ALUSrcA/ALUSrcB/PCSource; ALUOp class code; IllegalOp pulse; State for debug.
module multicycle_control #(
  parameter logic [3:0] PC_INC_OP = 4'b0100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, JR, ILLEGAL
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_alu_op;
  logic       w_is_r;
  logic       w_is_imm;
  logic       w_is_mem;
  logic       w_is_br;
  logic [3:0] w_imm_op;
  assign w_is_r   = Opcode == OP_R;
  assign w_is_imm = Opcode == OP_ADDI || Opcode == OP_ANDI || Opcode == OP_ORI || Opcode == OP_LUI;
  assign w_is_mem = Opcode == OP_LW || Opcode == OP_SW;
  assign w_is_br  = Opcode == OP_BEQ || Opcode == OP_BNE;
  assign w_imm_op = Opcode == OP_ANDI ? 4'b0101 :
                    Opcode == OP_ORI  ? 4'b0110 :
                    Opcode == OP_LUI  ? 4'b0011 : 4'b0100;
  assign State = r_state;
  // r_alu_op lets ALU_WB keep presenting the class code of the execute cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_alu_op <= PC_INC_OP;
    end else begin
      r_state  <= w_next;
      r_alu_op <= ALUOp;
    end
  end
  always_comb begin
    w_next    = FETCH;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    ALUOp     = PC_INC_OP;
    IllegalOp = 1'b0;
    case (r_state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        w_next  = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        w_next  = w_is_r   ? (Funct == FN_JR ? JR : EXEC_R) :
                  w_is_imm ? EXEC_I :
                  w_is_mem ? MEM_ADDR :
                  w_is_br  ? BRANCH :
                  Opcode == OP_J ? JUMP : ILLEGAL;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 4'b0111;
        w_next  = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = w_imm_op;
        w_next  = ALU_WB;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = w_is_r;
        ALUOp    = r_alu_op;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = Opcode == OP_SW ? 4'b1011 : 4'b1010;
        w_next  = Opcode == OP_SW ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = MEM_WB;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = Opcode == OP_BNE ? 4'b1001 : 4'b1000;
        PCSource = 2'b01;
        PCWrite  = (Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero);
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      JR: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
      ILLEGAL: IllegalOp = 1'b1;
      default: w_next = FETCH;
    endcase
    // an instruction caught by reset must leave no architectural side effects
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end
endmodule
